// File: rtl/unary_add_arb.sv
// unary_add_arb
//   Two-requester round-robin front end feeding a unary digit adder.
//   An accepted operand pair (A, B digits, clamped to RADIX-1) is fed one unary
//   unit per cycle into a 5-bit sum.  The sum is then split into a carry and a
//   digit, and the digit is emitted as a run of consecutive high cycles on dout.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/a/b/ready      requester N operand handshake (N = 0, 1)
//   busy                      a transaction is in progress (state != IDLE)
//   grant_id                  requester owning the current transaction
//   dout                      unary result stream, one high cycle per unit
//   C                         carry of the current result (WRITE and DONE only)
//   done, done_id             one-cycle end-of-transaction pulse and its owner
//
// state | meaning
// IDLE  | waiting for a valid request; ready high for the selected requester
// FEED  | one unary unit of each nonzero remainder added to the sum per cycle
// WRITE | result digit emitted on dout (one cycle minimum)
// DONE  | done pulse with the owning requester id
module unary_add_arb #(
  parameter int RADIX = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       busy,
  output logic       grant_id,
  output logic       dout,
  output logic       C,
  output logic       done,
  output logic       done_id
);

  typedef enum logic [1:0] {IDLE, FEED, WRITE, DONE} state_t;

  localparam logic [3:0] MAX_DIGIT = 4'(RADIX - 1);
  localparam logic [4:0] RADIX_W   = 5'(RADIX);

  state_t     state_q, state_d;
  logic [3:0] a_rem_q, a_rem_d;
  logic [3:0] b_rem_q, b_rem_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic [4:0] sum_q, sum_d;
  logic       carry_q, carry_d;
  logic       grant_id_q, grant_id_d;
  logic       last_q, last_d;
  logic       dout_q, dout_d;
  logic       c_q, c_d;
  logic       done_q, done_d;
  logic       done_id_q, done_id_d;

  logic       sel;
  logic       accept;
  logic [3:0] a_clamp, b_clamp;
  logic       a_bit, b_bit;
  logic [4:0] sum_next;
  logic [4:0] digit_w;

  function automatic logic [3:0] clamp(input logic [3:0] v);
    return (v > MAX_DIGIT) ? MAX_DIGIT : v;
  endfunction

  // A lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    if (req0_valid && !req1_valid)      sel = 1'b0;
    else if (req1_valid && !req0_valid) sel = 1'b1;
    else                                sel = ~last_q;
  end

  assign req0_ready = (state_q == IDLE) && !rst && !sel;
  assign req1_ready = (state_q == IDLE) && !rst &&  sel;
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  assign a_clamp    = clamp(sel ? req1_a : req0_a);
  assign b_clamp    = clamp(sel ? req1_b : req0_b);

  always_comb begin
    state_d    = state_q;
    a_rem_d    = a_rem_q;
    b_rem_d    = b_rem_q;
    wr_cnt_d   = wr_cnt_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    dout_d     = 1'b0;
    done_d     = 1'b0;
    done_id_d  = 1'b0;
    a_bit      = (a_rem_q != 4'd0);
    b_bit      = (b_rem_q != 4'd0);
    sum_next   = sum_q + {4'd0, a_bit} + {4'd0, b_bit};
    digit_w    = (sum_next >= RADIX_W) ? (sum_next - RADIX_W) : sum_next;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_rem_d    = a_clamp;
          b_rem_d    = b_clamp;
          grant_id_d = sel;
          last_d     = sel;
          sum_d      = 5'd0;
          if (a_clamp == 4'd0 && b_clamp == 4'd0) begin
            carry_d  = 1'b0;
            wr_cnt_d = 4'd0;
            state_d  = WRITE;
          end else begin
            state_d  = FEED;
          end
        end
      end
      FEED: begin
        sum_d = sum_next;
        if (a_bit) a_rem_d = a_rem_q - 4'd1;
        if (b_bit) b_rem_d = b_rem_q - 4'd1;
        // Last FEED cycle: both remainders hit zero after this decrement.
        if (a_rem_q <= 4'd1 && b_rem_q <= 4'd1) begin
          carry_d  = (sum_next >= RADIX_W);
          wr_cnt_d = digit_w[3:0];
          dout_d   = (digit_w != 5'd0);
          state_d  = WRITE;
        end
      end
      WRITE: begin
        // dout is registered, so the first pulse was launched on WRITE entry.
        if (wr_cnt_q > 4'd1) begin
          wr_cnt_d = wr_cnt_q - 4'd1;
          dout_d   = 1'b1;
        end else begin
          done_d    = 1'b1;
          done_id_d = grant_id_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    c_d = ((state_d == WRITE) || (state_d == DONE)) ? carry_d : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_rem_q    <= 4'd0;
      b_rem_q    <= 4'd0;
      wr_cnt_q   <= 4'd0;
      sum_q      <= 5'd0;
      carry_q    <= 1'b0;
      grant_id_q <= 1'b0;
      last_q     <= 1'b1;
      dout_q     <= 1'b0;
      c_q        <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_rem_q    <= a_rem_d;
      b_rem_q    <= b_rem_d;
      wr_cnt_q   <= wr_cnt_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      dout_q     <= dout_d;
      c_q        <= c_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;
  assign dout     = dout_q;
  assign C        = c_q;
  assign done     = done_q;
  assign done_id  = done_id_q;

endmodule

// File: tb/tb_unary_add_arb.sv
module tb_unary_add_arb;
  localparam int RADIX = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_ready, req1_ready;
  logic       busy, grant_id, dout, C, done, done_id;

  unary_add_arb #(.RADIX(RADIX)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .busy(busy), .grant_id(grant_id), .dout(dout), .C(C), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   model_last = 1;
  logic tr_c [0:81];

  typedef struct {
    int req;
    int a;
    int b;
    int exp_pulses;
    int exp_c;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > RADIX - 1) ? RADIX - 1 : v;
  endfunction

  // Arithmetic view of one transaction.
  task automatic model(input int a, input int b, output int dig, output int carry,
                       output int feed, output int lat);
    int ca, cb, s;
    ca    = clampv(a);
    cb    = clampv(b);
    s     = ca + cb;
    carry = (s >= RADIX) ? 1 : 0;
    dig   = s % RADIX;
    feed  = (ca > cb) ? ca : cb;
    lat   = feed + ((dig == 0) ? 1 : dig) + 1;
  endtask

  // Call at a negedge; returns just after the accepting posedge.
  task automatic wait_accept(input logic v0, input logic v1, input bit keep, output int acc);
    acc = -1;
    req0_valid = v0;
    req1_valid = v1;
    for (int w = 0; w < 200; w++) begin
      #1;
      if (req0_ready && req1_ready) chk("ready_onehot", 1, 0);
      if (req0_valid && req0_ready) acc = 0;
      else if (req1_valid && req1_ready) acc = 1;
      if (acc >= 0) break;
      @(negedge clk);
    end
    if (acc < 0) begin
      chk("accept_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1;
      if (!keep) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = 4'($urandom); req0_b = 4'($urandom);
        req1_a = 4'($urandom); req1_b = 4'($urandom);
      end
    end
  endtask

  task automatic trace(output int done_k, output int pulses, output int first_k,
                       output int last_k, output int id, output int done_after,
                       output int rdy_bad);
    done_k = 0; pulses = 0; first_k = 0; last_k = 0; id = -1;
    done_after = -1; rdy_bad = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      tr_c[k] = C;
      if (dout) begin
        pulses++;
        if (first_k == 0) first_k = k;
        last_k = k;
      end
      if (req0_ready || req1_ready) rdy_bad++;
      if (done) begin
        done_k = k;
        id = done_id;
        break;
      end
    end
    if (done_k != 0) begin
      @(negedge clk);
      done_after = done;
    end
  endtask

  task automatic run_txn(input string nm, input logic v0, input logic v1, input bit keep,
                         input int a, input int b, input int exp_id,
                         input int exp_pulses, input int exp_c);
    int acc, done_k, pulses, first_k, last_k, id, done_after, rdy_bad;
    int dig, carry, feed, lat, c_bad;
    model(a, b, dig, carry, feed, lat);
    wait_accept(v0, v1, keep, acc);
    chk({nm, "_grant"}, acc, exp_id);
    trace(done_k, pulses, first_k, last_k, id, done_after, rdy_bad);
    chk({nm, "_latency"}, done_k, lat);
    chk({nm, "_pulses"}, pulses, exp_pulses);
    chk({nm, "_pulses_model"}, pulses, dig);
    if (dig > 0) begin
      chk({nm, "_first_pulse"}, first_k, feed + 1);
      chk({nm, "_contiguous"}, last_k - first_k + 1, dig);
    end
    c_bad = 0;
    for (int k = 1; k <= done_k; k++)
      if (int'(tr_c[k]) != ((k > feed) ? carry : 0)) c_bad++;
    chk({nm, "_c_trace"}, c_bad, 0);
    if (done_k > 0) chk({nm, "_c_done"}, int'(tr_c[done_k]), exp_c);
    chk({nm, "_done_id"}, id, exp_id);
    chk({nm, "_done_1cyc"}, done_after, 0);
    chk({nm, "_ready_busy"}, rdy_bad, 0);
    model_last = exp_id;
  endtask

  vec_t vecs [6];
  int   acc, cnt_bad;

  initial begin
    vecs[0] = '{0,  3,  4, 7, 0};
    vecs[1] = '{1,  9,  9, 8, 1};
    vecs[2] = '{0,  5,  5, 0, 1};
    vecs[3] = '{0,  0,  0, 0, 0};
    vecs[4] = '{1, 12, 15, 8, 1};
    vecs[5] = '{1, 15,  0, 9, 0};

    // Reset state, with both requesters asking.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_c", C, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Continuous contention: alternating grants.
    req0_a = 1; req0_b = 1; req1_a = 1; req1_b = 1;
    for (int i = 0; i < 4; i++)
      run_txn($sformatf("rr%0d", i), 1'b1, 1'b1, 1'b1, 1, 1, i % 2, 2, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Directed vectors.
    foreach (vecs[i]) begin
      if (vecs[i].req == 0) begin
        req0_a = 4'(vecs[i].a); req0_b = 4'(vecs[i].b);
      end else begin
        req1_a = 4'(vecs[i].a); req1_b = 4'(vecs[i].b);
      end
      run_txn($sformatf("vec%0d", i), vecs[i].req == 0, vecs[i].req == 1, 1'b0,
              vecs[i].a, vecs[i].b, vecs[i].req, vecs[i].exp_pulses, vecs[i].exp_c);
    end

    // Randomized traffic against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      int mode, ga, gb, gid, dig, carry, feed, lat;
      mode = $urandom_range(0, 2);
      req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom);
      gid = (mode < 2) ? mode : 1 - model_last;
      ga  = (gid == 0) ? int'(req0_a) : int'(req1_a);
      gb  = (gid == 0) ? int'(req0_b) : int'(req1_b);
      model(ga, gb, dig, carry, feed, lat);
      run_txn($sformatf("rnd%0d", i), mode != 1, mode != 0, 1'b0, ga, gb, gid, dig, carry);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // Reset during the second FEED cycle of req0 7+2.
    req0_a = 7; req0_b = 2;
    wait_accept(1'b1, 1'b0, 1'b0, acc);
    chk("abort_grant", acc, 0);
    model_last = 0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_feed", busy, 1);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_dout", dout, 0);
    chk("abort_c", C, 0);
    chk("abort_done", done, 0);
    chk("abort_grant_id", grant_id, 0);
    chk("abort_ready0", req0_ready, 0);
    chk("abort_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    model_last = 1;
    cnt_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || dout || busy) cnt_bad++;
    end
    chk("abort_quiet", cnt_bad, 0);
    req0_a = 2; req0_b = 3; req1_a = 4; req1_b = 4;
    run_txn("after_abort", 1'b1, 1'b1, 1'b0, 2, 3, 0, 5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
